// File: rtl/sub_rr_arbiter.sv
// Round-robin arbiter granting one shared registered datapath to NUM_REQ requesters.
// Optional hold timeout with error pulse is built when SUB_ARB_HOLD_TIMEOUT_EN is defined.
module sub_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    input  logic [NUM_REQ-1:0] a_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               sub_a_o,
    output logic               sub_en_o,
    output logic               busy_o,
    output logic               err_o
);

    // state   | meaning
    // IDLE    | no holder, pick next winner from ptr
    // GRANT   | holder owns the shared unit
    // RELEASE | one dead cycle, pointer advances past holder
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        hold_idx_q, hold_idx_d;
    logic                 err_q, err_d;

    logic                 found;
    logic [IW-1:0]        win_idx;
    logic                 timeout;
    logic                 hold_done;
    logic                 hold_req;
    logic                 release_now;

    // Search ptr, ptr+1, ... for the first requester still asking.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = IW'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

`ifdef SUB_ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX) + 1;

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == S_IDLE && found) begin
            hold_cnt_d = '0;
        end else if (state_q == S_GRANT && hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign timeout = (state_q == S_GRANT) && (hold_cnt_q == CW'(HOLD_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    assign hold_done   = done_i[hold_idx_q];
    assign hold_req    = req_i[hold_idx_q];
    assign release_now = hold_done || !hold_req || timeout;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_idx_d = hold_idx_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_GRANT;
                    hold_idx_d = win_idx;
                    gnt_d      = NUM_REQ'(1) << win_idx;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
                    // A release the holder asked for (done or abandon) is never an error.
                    err_d   = timeout && !hold_done && hold_req;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                ptr_d   = (hold_idx_q == IW'(NUM_REQ - 1)) ? '0 : hold_idx_q + IW'(1);
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            hold_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_idx_q <= hold_idx_d;
            err_q      <= err_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign sub_en_o = (state_q == S_GRANT);
    assign sub_a_o  = (state_q == S_GRANT) ? a_i[hold_idx_q] : 1'b0;
    assign busy_o   = (state_q == S_GRANT) || (state_q == S_RELEASE);
    assign err_o    = err_q;

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// Self-checking bench for sub_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a holder/pointer level reference model.
module tb_sub_rr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int HOLD_MAX = 8;
`ifdef SUB_ARB_HOLD_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic               clk_i  = 1'b0;
    logic               rst_ni = 1'b1;
    logic [NUM_REQ-1:0] req_i  = '0;
    logic [NUM_REQ-1:0] done_i = '0;
    logic [NUM_REQ-1:0] a_i    = '0;
    logic [NUM_REQ-1:0] gnt_o;
    logic               sub_a_o, sub_en_o, busy_o, err_o;

    int n_checks = 0;
    int n_pass   = 0;

    sub_rr_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .done_i  (done_i),
        .a_i     (a_i),
        .gnt_o   (gnt_o),
        .sub_a_o (sub_a_o),
        .sub_en_o(sub_en_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who holds the unit, whether we are in the dead cycle,
    // and where the next search starts.
    int m_holder = -1;
    bit m_rel    = 1'b0;
    bit m_err    = 1'b0;
    int m_ptr    = 0;
    int m_len    = 0;
    int m_wait[NUM_REQ];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_holder = -1; m_rel = 1'b0; m_err = 1'b0; m_ptr = 0; m_len = 0;
            foreach (m_wait[i]) m_wait[i] = 0;
        end else if (m_holder >= 0) begin
            int h;
            bit d, r, t;
            h = m_holder; d = done_i[h]; r = req_i[h];
            t = TO && (m_len >= HOLD_MAX);
            if (d || !r || t) begin
                m_err    = t && !d && r;
                m_ptr    = (h + 1) % NUM_REQ;
                m_holder = -1;
                m_rel    = 1'b1;
            end else begin
                m_len++;
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
            m_err = 1'b0;
        end else begin
            int w;
            w = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && req_i[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            if (w >= 0) begin
                chk("fairness", 32'(m_wait[w] <= NUM_REQ - 1), 32'd1);
                for (int i = 0; i < NUM_REQ; i++)
                    m_wait[i] = (i != w && req_i[i]) ? m_wait[i] + 1 : 0;
                m_holder = w;
                m_len    = 1;
            end
        end
    end

    always @(negedge clk_i) begin
        logic [NUM_REQ-1:0] eg;
        eg = (m_holder >= 0) ? NUM_REQ'(1 << m_holder) : '0;
        chk("gnt", 32'(gnt_o), 32'(eg));
        chk("sub_en", 32'(sub_en_o), 32'(m_holder >= 0));
        chk("sub_a", 32'(sub_a_o), 32'((m_holder >= 0) ? a_i[m_holder] : 1'b0));
        chk("busy", 32'(busy_o), 32'((m_holder >= 0) || m_rel));
        chk("err", 32'(err_o), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        logic [NUM_REQ-1:0] e;
        #1 rst_ni = 1'b0;
        #12;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);

        // 1: full request set, rotate through every holder
        req_i = 4'b1111;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("t1_first", 32'(gnt_o), 32'h1);
        chk("t1_model_pin", 32'(m_holder), 32'd0);
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            chk("t1_gnt", 32'(gnt_o), 32'(e));
            done_i = e;
            tick();
            done_i = '0;
            chk("t1_gap1_gnt", 32'(gnt_o), 32'd0);
            chk("t1_gap1_busy", 32'(busy_o), 32'd1);
            tick();
            chk("t1_gap2_busy", 32'(busy_o), 32'd0);
            tick();
        end

        // 2: single requester, operand mux follows a_i[2]
        req_i = '0;
        tick(); tick();
        req_i = 4'b0100;
        tick();
        chk("t2_gnt", 32'(gnt_o), 32'h4);
        for (int k = 0; k < 6; k++) begin
            a_i = NUM_REQ'($urandom);
            #1 chk("t2_sub_a", 32'(sub_a_o), 32'(a_i[2]));
            tick();
        end
        done_i = 4'b0100;
        req_i  = '0;
        tick();
        done_i = '0;
        chk("t2_rel_gnt", 32'(gnt_o), 32'd0);
        chk("t2_rel_busy", 32'(busy_o), 32'd1);
        tick();
        chk("t2_idle_busy", 32'(busy_o), 32'd0);

        // 3: stray done ignored, abandon releases and advances ptr
        req_i = 4'b0010;
        tick();
        chk("t3_gnt", 32'(gnt_o), 32'h2);
        done_i = 4'b1000;
        tick();
        done_i = '0;
        chk("t3_stray", 32'(gnt_o), 32'h2);
        req_i = '0;
        tick();
        chk("t3_rel_gnt", 32'(gnt_o), 32'd0);
        chk("t3_rel_err", 32'(err_o), 32'd0);
        chk("t3_model_ptr", 32'(m_ptr), 32'd2);
        req_i = 4'b1111;
        tick(); tick();
        chk("t3_next", 32'(gnt_o), 32'h4);
        req_i = '0;
        tick(); tick();

`ifdef SUB_ARB_HOLD_TIMEOUT_EN
        // 4: holder never finishes, forced release after HOLD_MAX cycles
        req_i = 4'b0011;
        tick();
        chk("t4_gnt", 32'(gnt_o), 32'h1);
        n = 0;
        while (gnt_o != '0 && n < 50) begin
            n++;
            tick();
        end
        chk("t4_hold_len", 32'(n), 32'(HOLD_MAX));
        chk("t4_err_pulse", 32'(err_o), 32'd1);
        tick();
        chk("t4_err_clear", 32'(err_o), 32'd0);
        tick();
        chk("t4_next", 32'(gnt_o), 32'h2);
        // 5: done coincides with expiry, normal release
        for (int k = 0; k < HOLD_MAX - 1; k++) tick();
        done_i = 4'b0010;
        tick();
        done_i = '0;
        chk("t5_rel_gnt", 32'(gnt_o), 32'd0);
        chk("t5_rel_err", 32'(err_o), 32'd0);
        req_i = '0;
        tick(); tick();
`else
        // 5: no timeout, a long hold is kept
        req_i = 4'b0001;
        tick();
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (gnt_o == 4'b0001 && err_o == 1'b0) n++;
            tick();
        end
        chk("t5_long_hold", 32'(n), 32'd100);
        chk("t5_gnt", 32'(gnt_o), 32'h1);
        req_i = '0;
        tick(); tick();
`endif

        // 6: asynchronous reset mid-grant
        req_i = 4'b1100;
        tick();
        chk("t6_pre", 32'(gnt_o != '0), 32'd1);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk("t6_gnt", 32'(gnt_o), 32'd0);
        chk("t6_en", 32'(sub_en_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        req_i = 4'b1010;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("t6_first", 32'(gnt_o), 32'h2);
        req_i = '0;
        tick(); tick();

        // Randomized traffic: requests are sticky until their holder lets go.
        for (int c = 0; c < 3000; c++) begin
            done_i = '0;
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_i[i] && $urandom_range(0, 3) == 0) req_i[i] = 1'b1;
            if (m_holder >= 0) begin
                case ($urandom_range(0, 5))
                    0: done_i[m_holder] = 1'b1;
                    1: req_i[m_holder] = 1'b0;
                    2: begin done_i[m_holder] = 1'b1; req_i[m_holder] = 1'b0; end
                    default: ;
                endcase
                if ($urandom_range(0, 3) == 0)
                    done_i = done_i | (NUM_REQ'($urandom) & ~NUM_REQ'(1 << m_holder));
            end
            a_i = NUM_REQ'($urandom);
            tick();
        end

        req_i  = '0;
        done_i = '0;
        tick(); tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
